// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int unsigned PC_INC     = 4;
  localparam int unsigned IW_DEFAULT = 32;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Architectural program counter register with load enable.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) pc_d = load_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencing and single-outstanding instruction fetch between the PC stage and decode.
//
//   state | meaning
//   BOOT  | one idle cycle after reset release
//   REQ   | request phase for address pc (request raised the cycle after entry)
//   WAIT  | request granted, waiting for rvalid
//   HOLD  | instruction parked while decode stalls, no request
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      IW       = IW_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [IW-1:0]    imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             instr_valid,
  output logic [IW-1:0]    instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] pc
);

  fetch_state_t     state_d, state_q;
  logic             kill_d, kill_q;
  logic             imem_req_d, imem_req_q;
  logic             instr_valid_d, instr_valid_q;
  logic [IW-1:0]    instr_d, instr_q;
  logic [WIDTH-1:0] instr_pc_d, instr_pc_q;

  logic             pc_load;
  logic [WIDTH-1:0] pc_next;
  logic             gnt_ok;

  pc_reg #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_load),
    .load_val(pc_next),
    .pc      (pc)
  );

  // A grant only counts against a request we actually presented.
  assign gnt_ok = imem_req_q & imem_gnt;

  always_comb begin
    state_d       = state_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q & stall;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_load       = 1'b0;
    pc_next       = pc;

    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (gnt_ok)                       state_d = WAIT;
        else if (instr_valid_q && stall)  state_d = HOLD;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            pc_load       = 1'b1;
            pc_next       = pc + WIDTH'(PC_INC);
            state_d       = stall ? HOLD : REQ;
          end
        end
      end
      HOLD: begin
        if (!(instr_valid_q && stall)) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase

    // Redirect overrides everything above; an in-flight word is killed on return.
    if (redirect) begin
      pc_load       = 1'b1;
      pc_next       = {redirect_pc[WIDTH-1:2], 2'b00};
      instr_valid_d = 1'b0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      unique case (state_q)
        WAIT: begin
          kill_d  = ~imem_rvalid;
          state_d = imem_rvalid ? REQ : WAIT;
        end
        REQ: begin
          kill_d  = gnt_ok;
          state_d = gnt_ok ? WAIT : REQ;
        end
        default: state_d = REQ;
      endcase
    end

    // Request is registered: raised only while staying in REQ, withdrawn on grant or redirect.
    imem_req_d = (state_q == REQ) && (state_d == REQ) && !redirect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      kill_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances (RESET_PC 0 and FFFF_FFFC) with a simple memory model.
module tb_fetch_sequencer;

  localparam logic [31:0] MAGIC = 32'hC0DE_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  // instance A controls
  logic        gnt_en, rv_en, a_redirect, a_stall;
  logic [31:0] a_redirect_pc;
  logic        a_req, a_gnt, a_rvalid, a_instr_valid;
  logic [31:0] a_addr, a_rdata, a_instr, a_instr_pc, a_pc;
  logic        a_pend;
  logic [31:0] a_paddr;

  // instance B: free-running fetch from the top of the address space
  logic        b_req, b_gnt, b_rvalid, b_instr_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_instr_pc, b_pc;
  logic        b_pend;
  logic [31:0] b_paddr;

  fetch_sequencer #(.WIDTH(32), .IW(32), .RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(a_gnt),
    .imem_rvalid(a_rvalid), .imem_rdata(a_rdata),
    .redirect(a_redirect), .redirect_pc(a_redirect_pc), .stall(a_stall),
    .instr_valid(a_instr_valid), .instr(a_instr), .instr_pc(a_instr_pc), .pc(a_pc)
  );

  fetch_sequencer #(.WIDTH(32), .IW(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc), .pc(b_pc)
  );

  // memory: grant when enabled, data one cycle (or more, via rv_en) after grant
  assign a_gnt    = a_req & gnt_en;
  assign a_rvalid = a_pend & rv_en;
  assign a_rdata  = a_paddr ^ MAGIC;
  assign b_gnt    = b_req;
  assign b_rvalid = b_pend;
  assign b_rdata  = b_paddr ^ MAGIC;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_req && a_gnt) begin
      a_pend  <= 1'b1;
      a_paddr <= a_addr;
    end else if (a_rvalid) a_pend <= 1'b0;
    if (b_req && b_gnt) begin
      b_pend  <= 1'b1;
      b_paddr <= b_addr;
    end else if (b_rvalid) b_pend <= 1'b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    gnt_en = 1'b1; rv_en = 1'b1; a_stall = 1'b0;
    a_redirect = 1'b0; a_redirect_pc = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input bit sel, input logic [31:0] exp_addr, input string tag);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      r = sel ? b_req : a_req;
      if (r) break;
    end
    chk({tag, "_req"}, {31'd0, r}, 32'd1);
    chk({tag, "_addr"}, sel ? b_addr : a_addr, exp_addr);
  endtask

  task automatic wait_valid(input bit sel, input logic [31:0] exp_pc, input string tag,
                            output int seen_cyc);
    logic v;
    v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      v = sel ? b_instr_valid : a_instr_valid;
      if (v) break;
    end
    seen_cyc = cyc;
    chk({tag, "_valid"}, {31'd0, v}, 32'd1);
    chk({tag, "_ipc"}, sel ? b_instr_pc : a_instr_pc, exp_pc);
    chk({tag, "_instr"}, sel ? b_instr : a_instr, exp_pc ^ MAGIC);
  endtask

  task automatic fetch_one(input bit sel, input logic [31:0] a, input string tag, output int seen_cyc);
    wait_req(sel, a, tag);
    wait_valid(sel, a, tag, seen_cyc);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0, t1, t2, tx;
    checks = 0; failures = 0;
    a_pend = 1'b0; b_pend = 1'b0; a_paddr = '0; b_paddr = '0;
    gnt_en = 1'b1; rv_en = 1'b1; a_stall = 1'b0;
    a_redirect = 1'b0; a_redirect_pc = '0;
    rst_n = 1'b0;
    step(); step();

    // reset state
    chk("rst_req", {31'd0, a_req}, 32'd0);
    chk("rst_valid", {31'd0, a_instr_valid}, 32'd0);
    chk("rst_instr", a_instr, 32'd0);
    chk("rst_ipc", a_instr_pc, 32'd0);
    chk("rst_pc_a", a_pc, 32'h0000_0000);
    chk("rst_pc_b", b_pc, 32'hFFFF_FFFC);

    // 1: back-to-back fetch, one instruction per 3 cycles
    rst_n = 1'b1;
    fetch_one(0, 32'h0, "t1a", t0);
    fetch_one(0, 32'h4, "t1b", t1);
    fetch_one(0, 32'h8, "t1c", t2);
    chk("t1_gap01", t1 - t0, 32'd3);
    chk("t1_gap12", t2 - t1, 32'd3);

    // 2: stall holds instr_pc=4 with no request, release fetches 8
    do_reset();
    fetch_one(0, 32'h0, "t2a", tx);
    fetch_one(0, 32'h4, "t2b", tx);
    a_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", {31'd0, a_instr_valid}, 32'd1);
      chk("t2_hold_ipc", a_instr_pc, 32'h4);
      chk("t2_hold_req", {31'd0, a_req}, 32'd0);
    end
    a_stall = 1'b0;
    step();
    chk("t2_consumed", {31'd0, a_instr_valid}, 32'd0);
    fetch_one(0, 32'h8, "t2c", tx);

    // 3: redirect in WAIT before rvalid kills the returning word
    do_reset();
    fetch_one(0, 32'h0, "t3a", tx);
    fetch_one(0, 32'h4, "t3b", tx);
    rv_en = 1'b0;
    wait_req(0, 32'h8, "t3_req8");
    step();
    a_redirect = 1'b1; a_redirect_pc = 32'h100;
    step();
    a_redirect = 1'b0;
    chk("t3_pc", a_pc, 32'h100);
    chk("t3_valid_a", {31'd0, a_instr_valid}, 32'd0);
    rv_en = 1'b1;
    step();
    chk("t3_drop_valid", {31'd0, a_instr_valid}, 32'd0);
    chk("t3_drop_ipc", a_instr_pc, 32'h4);
    fetch_one(0, 32'h100, "t3c", tx);

    // 4: redirect with rvalid in the same cycle drops the word; low pc bits forced to 0
    do_reset();
    fetch_one(0, 32'h0, "t4a", tx);
    fetch_one(0, 32'h4, "t4b", tx);
    wait_req(0, 32'h8, "t4_req8");
    step();
    a_redirect = 1'b1; a_redirect_pc = 32'h103;
    step();
    a_redirect = 1'b0;
    chk("t4_valid", {31'd0, a_instr_valid}, 32'd0);
    chk("t4_ipc", a_instr_pc, 32'h4);
    chk("t4_pc", a_pc, 32'h100);
    fetch_one(0, 32'h100, "t4c", tx);

    // 5: PC wraps from FFFF_FFFC to 0
    do_reset();
    fetch_one(1, 32'hFFFF_FFFC, "t5a", tx);
    wait_req(1, 32'h0, "t5b");

    // 6: reset mid-WAIT, stale rvalid during BOOT is ignored
    do_reset();
    fetch_one(0, 32'h0, "t6a", tx);
    rv_en = 1'b0;
    wait_req(0, 32'h4, "t6_req4");
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, a_req}, 32'd0);
    chk("t6_rst_pc", a_pc, 32'h0);
    step();
    rst_n = 1'b1;
    rv_en = 1'b1;
    step();
    chk("t6_boot_valid", {31'd0, a_instr_valid}, 32'd0);
    fetch_one(0, 32'h0, "t6b", tx);

    // 7: redirect in REQ coinciding with grant: outstanding word is killed
    do_reset();
    wait_req(0, 32'h0, "t7_req0");
    a_redirect = 1'b1; a_redirect_pc = 32'h200;
    step();
    a_redirect = 1'b0;
    step();
    chk("t7_drop_valid", {31'd0, a_instr_valid}, 32'd0);
    fetch_one(0, 32'h200, "t7b", tx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
